// File: rtl/router_pkg.sv
// router_pkg: shared widths and constants for the router register block
package router_pkg;
  localparam int DATA_WIDTH = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
  typedef logic [DATA_WIDTH-1:0] byte_t;
endpackage

// File: rtl/router_reg_if.sv
// router_reg_if: FSM decodes, source byte stream and FIFO-side outputs of the register block
interface router_reg_if;
  import router_pkg::*;
  logic pkt_valid;
  byte_t data_in;
  logic fifo_full;
  logic detect_add;
  logic lfd_state;
  logic ld_state;
  logic laf_state;
  logic full_state;
  logic rst_int_reg;
  byte_t dout;
  logic parity_done;
  logic low_pkt_valid;
  logic err;
  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );
  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_parity.sv
// router_parity: running XOR of accepted bytes, captured packet parity and mismatch flag
module router_parity
  import router_pkg::*;
(
  input  logic  clock,
  input  logic  resetn,
  input  logic  clr_i,
  input  logic  lfd_i,
  input  logic  ld_i,
  input  logic  laf_i,
  input  logic  hold_i,
  input  logic  pkt_valid_i,
  input  logic  fifo_full_i,
  input  logic  low_pkt_valid_i,
  input  logic  parity_done_i,
  input  logic  rst_int_reg_i,
  input  byte_t data_in_i,
  input  byte_t header_i,
  input  byte_t full_byte_i,
  output logic  err_o
);
  byte_t ip_q, ip_d, pp_q, pp_d;
  logic err_q, err_d;
  always_comb begin
    ip_d = clr_i ? '0 :
           hold_i ? ip_q :
           lfd_i ? ip_q ^ header_i :
           (ld_i & pkt_valid_i & ~fifo_full_i) ? ip_q ^ data_in_i :
           (laf_i & ~low_pkt_valid_i) ? ip_q ^ full_byte_i : ip_q;
    pp_d = (clr_i | hold_i) ? pp_q :
           (ld_i & ~pkt_valid_i & ~fifo_full_i) ? data_in_i :
           (laf_i & low_pkt_valid_i) ? full_byte_i : pp_q;
    err_d = clr_i ? 1'b0 : (parity_done_i & rst_int_reg_i) ? (ip_q != pp_q) : err_q;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      ip_q <= '0;
      pp_q <= '0;
      err_q <= 1'b0;
    end else begin
      ip_q <= ip_d;
      pp_q <= pp_d;
      err_q <= err_d;
    end
  assign err_o = err_q;
endmodule

// File: rtl/router_reg.sv
// router_reg: header/full-byte holding, output byte mux and packet-end status for the router
module router_reg
  import router_pkg::*;
(
  input logic clock,
  input logic resetn,
  router_reg_if.slave rif
);
  byte_t dout_q, dout_d, header_q, header_d, full_q, full_d;
  logic pd_q, pd_d, low_q, low_d;
  logic lfd_go, ld_go, laf_go, err;
  // illegal simultaneous decodes resolve as detect_add > lfd > ld > laf
  assign lfd_go = ~rif.detect_add & rif.lfd_state;
  assign ld_go  = ~rif.detect_add & ~rif.lfd_state & rif.ld_state;
  assign laf_go = ~rif.detect_add & ~rif.lfd_state & ~rif.ld_state & rif.laf_state;
  always_comb begin
    header_d = (rif.detect_add & rif.pkt_valid & (rif.data_in[1:0] != ADDR_INVALID)) ? rif.data_in : header_q;
    dout_d = (rif.detect_add | rif.full_state) ? dout_q :
             lfd_go ? header_q :
             (ld_go & ~rif.fifo_full) ? rif.data_in :
             laf_go ? full_q : dout_q;
    full_d = (ld_go & rif.fifo_full & ~rif.full_state) ? rif.data_in : full_q;
    pd_d = rif.detect_add ? 1'b0 :
           ((ld_go & ~rif.fifo_full & ~rif.pkt_valid) | (laf_go & low_q & ~pd_q)) ? 1'b1 : pd_q;
    low_d = rif.rst_int_reg ? 1'b0 : (ld_go & ~rif.pkt_valid) ? 1'b1 : low_q;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      dout_q <= '0;
      header_q <= '0;
      full_q <= '0;
      pd_q <= 1'b0;
      low_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      header_q <= header_d;
      full_q <= full_d;
      pd_q <= pd_d;
      low_q <= low_d;
    end
  router_parity u_parity (
    .clock           (clock),
    .resetn          (resetn),
    .clr_i           (rif.detect_add),
    .lfd_i           (lfd_go),
    .ld_i            (ld_go),
    .laf_i           (laf_go),
    .hold_i          (rif.full_state),
    .pkt_valid_i     (rif.pkt_valid),
    .fifo_full_i     (rif.fifo_full),
    .low_pkt_valid_i (low_q),
    .parity_done_i   (pd_q),
    .rst_int_reg_i   (rif.rst_int_reg),
    .data_in_i       (rif.data_in),
    .header_i        (header_q),
    .full_byte_i     (full_q),
    .err_o           (err)
  );
  assign rif.dout = dout_q;
  assign rif.parity_done = pd_q;
  assign rif.low_pkt_valid = low_q;
  assign rif.err = err;
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed packet scenarios plus random one-hot decode traffic against a byte-list model
module tb_router_reg;
  localparam logic [5:0] NONE = 6'd0, DA = 6'd1, LFD = 6'd2, LD = 6'd4, LAF = 6'd8, FS = 6'd16, RI = 6'd32;
  logic clock = 1'b0;
  logic resetn;
  int total = 0, bad = 0;
  router_reg_if rif ();
  router_reg dut (.clock(clock), .resetn(resetn), .rif(rif));
  always #5 clock = ~clock;
  logic [7:0] m_dout, m_hdr, m_full, m_pp;
  logic m_pd, m_low, m_err;
  logic [7:0] acc[$];
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] fold();
    logic [7:0] r = 8'h00;
    foreach (acc[i]) r ^= acc[i];
    return r;
  endfunction
  task automatic model_reset();
    m_dout = 0; m_hdr = 0; m_full = 0; m_pp = 0; m_pd = 0; m_low = 0; m_err = 0;
    acc.delete();
  endtask
  task automatic model_step(input logic [5:0] dec, input logic pv, input logic [7:0] d, input logic ff);
    logic o_pd, o_low;
    o_pd = m_pd;
    o_low = m_low;
    if (dec == DA) begin
      if (pv && d[1:0] != 2'b11) m_hdr = d;
      acc.delete();
      m_pd = 0;
      m_err = 0;
    end else if (dec == LFD) begin
      m_dout = m_hdr;
      acc.push_back(m_hdr);
    end else if (dec == LD) begin
      if (ff) m_full = d;
      else begin
        m_dout = d;
        if (pv) acc.push_back(d);
        else begin
          m_pp = d;
          m_pd = 1;
        end
      end
      if (!pv) m_low = 1;
    end else if (dec == LAF) begin
      m_dout = m_full;
      if (!o_low) acc.push_back(m_full);
      else begin
        m_pp = m_full;
        m_pd = 1;
      end
    end else if (dec == RI) begin
      m_low = 0;
      if (o_pd) m_err = (fold() != m_pp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_dout"}, rif.dout, m_dout);
    chk({tag, "_pd"}, {7'd0, rif.parity_done}, {7'd0, m_pd});
    chk({tag, "_low"}, {7'd0, rif.low_pkt_valid}, {7'd0, m_low});
    chk({tag, "_err"}, {7'd0, rif.err}, {7'd0, m_err});
  endtask
  task automatic cyc(input logic [5:0] dec, input logic pv, input logic [7:0] d, input logic ff, input string tag);
    {rif.rst_int_reg, rif.full_state, rif.laf_state, rif.ld_state, rif.lfd_state, rif.detect_add} = dec;
    rif.pkt_valid = pv;
    rif.data_in = d;
    rif.fifo_full = ff;
    @(posedge clock);
    model_step(dec, pv, d, ff);
    #1 check_all(tag);
  endtask
  task automatic packet_head();
    cyc(DA, 1, 8'h0D, 0, "hd");
    cyc(LFD, 1, 8'h11, 0, "lfd");
    chk("hdr_out", rif.dout, 8'h0D);
    cyc(LD, 1, 8'h11, 0, "ld11");
  endtask
  initial begin
    resetn = 1'b0;
    {rif.rst_int_reg, rif.full_state, rif.laf_state, rif.ld_state, rif.lfd_state, rif.detect_add} = NONE;
    rif.pkt_valid = 0; rif.data_in = 0; rif.fifo_full = 0;
    model_reset();
    #12;
    check_all("rst");
    resetn = 1'b1;
    // good packet
    packet_head();
    cyc(LD, 1, 8'h22, 0, "ld22");
    chk("good_d22", rif.dout, 8'h22);
    cyc(LD, 1, 8'h33, 0, "ld33");
    cyc(LD, 0, 8'h0D, 0, "ldpar");
    chk("good_par", rif.dout, 8'h0D);
    chk("good_pd", {7'd0, rif.parity_done}, 8'd1);
    cyc(RI, 0, 8'h00, 0, "ri");
    chk("good_err", {7'd0, rif.err}, 8'd0);
    // bad parity
    packet_head();
    cyc(LD, 1, 8'h22, 0, "b22");
    cyc(LD, 1, 8'h33, 0, "b33");
    cyc(LD, 0, 8'h0E, 0, "bpar");
    cyc(RI, 0, 8'h00, 0, "bri");
    chk("bad_err", {7'd0, rif.err}, 8'd1);
    cyc(DA, 1, 8'h0D, 0, "bda");
    chk("bad_clr", {7'd0, rif.err}, 8'd0);
    // fifo full mid payload
    cyc(LFD, 1, 8'h11, 0, "flfd");
    cyc(LD, 1, 8'h11, 0, "f11");
    cyc(LD, 1, 8'h22, 1, "f22");
    chk("full_hold", rif.dout, 8'h11);
    for (int i = 0; i < 3; i++) cyc(FS, 1, 8'h33, 1, "fs");
    chk("full_hold3", rif.dout, 8'h11);
    cyc(LAF, 1, 8'h33, 0, "flaf");
    chk("full_laf", rif.dout, 8'h22);
    cyc(LD, 1, 8'h33, 0, "f33");
    cyc(LD, 0, 8'h0D, 0, "fpar");
    cyc(RI, 0, 8'h00, 0, "fri");
    chk("full_err", {7'd0, rif.err}, 8'd0);
    // parity byte arrives while full
    packet_head();
    cyc(LD, 1, 8'h22, 0, "p22");
    cyc(LD, 1, 8'h33, 0, "p33");
    cyc(LD, 0, 8'h0D, 1, "ppar");
    chk("lp_low", {7'd0, rif.low_pkt_valid}, 8'd1);
    chk("lp_pd0", {7'd0, rif.parity_done}, 8'd0);
    cyc(FS, 0, 8'h00, 1, "pfs");
    cyc(LAF, 0, 8'h00, 0, "plaf");
    chk("lp_dout", rif.dout, 8'h0D);
    chk("lp_pd", {7'd0, rif.parity_done}, 8'd1);
    cyc(RI, 0, 8'h00, 0, "pri");
    chk("lp_err", {7'd0, rif.err}, 8'd0);
    // address 3 ignored
    cyc(DA, 1, 8'h0F, 0, "a3");
    chk("a3_dout", rif.dout, 8'h0D);
    cyc(LFD, 1, 8'h0F, 0, "a3lfd");
    chk("a3_hdr", rif.dout, 8'h0D);
    // async reset mid packet
    cyc(DA, 1, 8'h16, 0, "rda");
    cyc(LFD, 1, 8'h00, 0, "rlfd");
    cyc(LD, 0, 8'hA5, 0, "rld");
    rif.ld_state = 1; rif.data_in = 8'h5A;
    resetn = 1'b0;
    model_reset();
    #1 check_all("arst");
    #6 resetn = 1'b1;
    {rif.rst_int_reg, rif.full_state, rif.laf_state, rif.ld_state, rif.lfd_state, rif.detect_add} = NONE;
    // random one-hot traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] dec;
      dec = (6'd1 << $urandom_range(0, 5)) & {6{$urandom_range(0, 6) != 0}};
      cyc(dec, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0), "rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
